// File: rtl/vga_color_processor_if.sv
// Pixel-path bundle between the colour processor and its buffer, CLUT bus and RGB FIFO.
// master = colour processor side, slave = surrounding video controller.
// No storage; pure wiring.
interface vga_color_processor_if;
    logic        ctrl_ven;
    logic [1:0]  ColorDepth;
    logic        PseudoColor;
    logic [31:0] pixel_buffer_di;
    logic        pixel_buffer_empty;
    logic        pixel_buffer_rreq;
    logic [31:0] wb_di;
    logic        clut_req;
    logic [7:0]  clut_offs;
    logic        clut_ack;
    logic        RGB_fifo_full;
    logic        RGB_fifo_wreq;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;

    modport master (
        input  ctrl_ven, ColorDepth, PseudoColor,
        input  pixel_buffer_di, pixel_buffer_empty,
        output pixel_buffer_rreq,
        input  wb_di, clut_ack,
        output clut_req, clut_offs,
        input  RGB_fifo_full,
        output RGB_fifo_wreq, R, G, B
    );

    modport slave (
        output ctrl_ven, ColorDepth, PseudoColor,
        output pixel_buffer_di, pixel_buffer_empty,
        input  pixel_buffer_rreq,
        output wb_di, clut_ack,
        input  clut_req, clut_offs,
        output RGB_fifo_full,
        input  RGB_fifo_wreq, R, G, B
    );
endinterface

// File: rtl/vga_color_processor.sv
// Unpacks 32-bit pixel-buffer words into 24-bit RGB pixels (8/16/24/32bpp, 8bpp CLUT); VGA_COLPROC_BITFILL_EN selects 16bpp MSB-replication fill.
// Latency: word popped on one edge, first pixel pushed on the next; CLUT pixels follow their ack edge.
// Backpressure: RGB_fifo_full stalls emission and popping; an empty buffer idles the FSM without popping.
module vga_color_processor (
    input  logic                          clk,
    input  logic                          rst,
    vga_color_processor_if.master         bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PIX  = 2'd1;
    localparam logic [1:0] ST_CLUT = 2'd2;

    localparam logic [1:0] D8  = 2'b00;
    localparam logic [1:0] D16 = 2'b01;
    localparam logic [1:0] D24 = 2'b10;
    localparam logic [1:0] D32 = 2'b11;

    logic [1:0]  r_state;
    logic [31:0] r_word;
    logic [31:0] r_prev;
    logic [1:0]  r_depth;
    logic        r_pseudo;
    logic [1:0]  r_idx;
    logic [1:0]  r_phase;
    logic        r_clut_req;
    logic [7:0]  r_clut_offs;
    logic        r_wreq;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [7:0]  r_b;

    logic        w_clr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [23:0] w_pix24;
    logic [7:0]  w_r565;
    logic [7:0]  w_g565;
    logic [7:0]  w_b565;
    logic [23:0] w_rgb;
    logic        w_last;
    logic        w_clut_mode;
    logic        w_emit_direct;
    logic        w_emit_clut;
    logic        w_emit;
    logic        w_need;
    logic        w_pop;
    logic [1:0]  w_phase_nxt;
    logic        w_keep24;
    logic        w_unused;

    assign w_clr    = rst || !bus.ctrl_ven;
    assign w_unused = &{1'b0, bus.wb_di[31:24]};

    always_comb begin
        w_byte = r_word[31:24];
        case (r_idx)
            2'd1:    w_byte = r_word[23:16];
            2'd2:    w_byte = r_word[15:8];
            2'd3:    w_byte = r_word[7:0];
            default: w_byte = r_word[31:24];
        endcase
    end

    assign w_half = r_idx[0] ? r_word[15:0] : r_word[31:16];

`ifdef VGA_COLPROC_BITFILL_EN
    assign w_r565 = {w_half[15:11], w_half[15:13]};
    assign w_g565 = {w_half[10:5],  w_half[10:9]};
    assign w_b565 = {w_half[4:0],   w_half[4:2]};
`else
    assign w_r565 = {w_half[15:11], 3'b000};
    assign w_g565 = {w_half[10:5],  2'b00};
    assign w_b565 = {w_half[4:0],   3'b000};
`endif

    // 24bpp: phases 1 and 2 straddle words, so the previous word is kept in r_prev.
    always_comb begin
        w_pix24 = r_word[31:8];
        case (r_phase)
            2'd1:    w_pix24 = {r_prev[7:0],  r_word[31:16]};
            2'd2:    w_pix24 = {r_prev[15:0], r_word[31:24]};
            2'd3:    w_pix24 = r_word[23:0];
            default: w_pix24 = r_word[31:8];
        endcase
    end

    always_comb begin
        w_rgb  = r_word[23:0];
        w_last = 1'b1;
        case (r_depth)
            D8: begin
                w_rgb  = {w_byte, w_byte, w_byte};
                w_last = (r_idx == 2'd3);
            end
            D16: begin
                w_rgb  = {w_r565, w_g565, w_b565};
                w_last = r_idx[0];
            end
            D24: begin
                w_rgb  = w_pix24;
                w_last = (r_phase != 2'd2);
            end
            D32: begin
                w_rgb  = r_word[23:0];
                w_last = 1'b1;
            end
            default: begin
                w_rgb  = r_word[23:0];
                w_last = 1'b1;
            end
        endcase
    end

    assign w_clut_mode   = (r_depth == D8) && r_pseudo;
    assign w_emit_direct = (r_state == ST_PIX) && !w_clut_mode && !bus.RGB_fifo_full;
    assign w_emit_clut   = (r_state == ST_CLUT) && r_clut_req && bus.clut_ack;
    assign w_emit        = w_emit_direct || w_emit_clut;
    assign w_need        = (r_state == ST_IDLE) || (w_emit && w_last);
    assign w_pop         = !w_clr && w_need && !bus.pixel_buffer_empty;

    assign w_phase_nxt = (r_depth == D24 && w_emit) ? r_phase + 2'd1 : r_phase;
    // Mid-group 24bpp fetches must not pick up a depth change.
    assign w_keep24    = (r_depth == D24) && (w_phase_nxt != 2'd0);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state     <= ST_IDLE;
            r_word      <= 32'h0;
            r_prev      <= 32'h0;
            r_depth     <= D8;
            r_pseudo    <= 1'b0;
            r_idx       <= 2'd0;
            r_phase     <= 2'd0;
            r_clut_req  <= 1'b0;
            r_clut_offs <= 8'h0;
            r_wreq      <= 1'b0;
            r_r         <= 8'h0;
            r_g         <= 8'h0;
            r_b         <= 8'h0;
        end else begin
            r_wreq <= 1'b0;

            if (w_emit_direct) begin
                r_wreq            <= 1'b1;
                {r_r, r_g, r_b}   <= w_rgb;
                r_idx             <= r_idx + 2'd1;
                r_phase           <= w_phase_nxt;
            end

            if (w_emit_clut) begin
                r_wreq            <= 1'b1;
                {r_r, r_g, r_b}   <= bus.wb_di[23:0];
                r_clut_req        <= 1'b0;
                r_idx             <= r_idx + 2'd1;
                r_state           <= ST_PIX;
            end

            if (r_state == ST_PIX && w_clut_mode && !bus.RGB_fifo_full) begin
                r_clut_req  <= 1'b1;
                r_clut_offs <= w_byte;
                r_state     <= ST_CLUT;
            end

            // Word fetch overrides index/state so the next word starts on the emitting edge.
            if (w_need) begin
                if (!bus.pixel_buffer_empty) begin
                    r_word  <= bus.pixel_buffer_di;
                    r_prev  <= r_word;
                    r_idx   <= 2'd0;
                    r_state <= ST_PIX;
                    if (!w_keep24) begin
                        r_depth  <= bus.ColorDepth;
                        r_pseudo <= bus.PseudoColor;
                    end
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign bus.pixel_buffer_rreq = w_pop;
    assign bus.clut_req          = r_clut_req;
    assign bus.clut_offs         = r_clut_offs;
    assign bus.RGB_fifo_wreq     = r_wreq;
    assign bus.R                 = r_r;
    assign bus.G                 = r_g;
    assign bus.B                 = r_b;

endmodule

// File: tb/tb_vga_color_processor.sv
// Directed bench for vga_color_processor: pixel buffer model, RGB push monitor, per-feature tasks.
module tb_vga_color_processor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_color_processor_if bus();

    vga_color_processor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [31:0] pbq[$];
    logic [23:0] wq[$];
    int          wc[$];
    int          cyc      = 0;
    int          rreq_cnt = 0;
    int          bad_pop  = 0;
    logic        pop_s;

    always @(posedge clk) cyc++;

    // First-word-fall-through buffer model; only this process drives di/empty.
    initial begin
        bus.pixel_buffer_empty = 1'b1;
        bus.pixel_buffer_di    = 32'h0;
        forever begin
            @(posedge clk);
            pop_s = bus.pixel_buffer_rreq;
            #1;
            if (pop_s && pbq.size() > 0) begin
                void'(pbq.pop_front());
                rreq_cnt++;
            end
            bus.pixel_buffer_empty = (pbq.size() == 0);
            bus.pixel_buffer_di    = (pbq.size() > 0) ? pbq[0] : 32'h0;
        end
    end

    always @(negedge clk) begin
        if (bus.RGB_fifo_wreq) begin
            wq.push_back({bus.R, bus.G, bus.B});
            wc.push_back(cyc);
        end
        if (bus.pixel_buffer_rreq && bus.pixel_buffer_empty) bad_pop++;
    end

    task automatic push_word(input logic [31:0] w);
        pbq.push_back(w);
    endtask

    task automatic wait_pix(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (wq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [23:0] pix_at(input int i);
        logic [23:0] v;
        v = 24'hxxxxxx;
        if (i < wq.size()) v = wq[i];
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.ctrl_ven = 1'b1;
        bus.ColorDepth = 2'b00;
        bus.PseudoColor = 1'b0;
        bus.wb_di = 32'h0;
        bus.clut_ack = 1'b0;
        bus.RGB_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.RGB_fifo_wreq !== 1'b0) $display("FAIL reset_wreq got %b want 0", bus.RGB_fifo_wreq); else passed++;
        checks++; if (bus.clut_req !== 1'b0) $display("FAIL reset_clut_req got %b want 0", bus.clut_req); else passed++;
        checks++; if (bus.clut_offs !== 8'h00) $display("FAIL reset_clut_offs got %h want 00", bus.clut_offs); else passed++;
        checks++; if ({bus.R, bus.G, bus.B} !== 24'h0) $display("FAIL reset_rgb got %h want 000000", {bus.R, bus.G, bus.B}); else passed++;
        checks++; if (bus.pixel_buffer_rreq !== 1'b0) $display("FAIL reset_rreq got %b want 0", bus.pixel_buffer_rreq); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8bpp_grey();
        logic [23:0] exp [4];
        int b, r0;
        bit ok;
        exp = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        bus.ColorDepth = 2'b00; bus.PseudoColor = 1'b0; bus.RGB_fifo_full = 1'b0;
        b = wq.size(); r0 = rreq_cnt;
        push_word(32'h11223344);
        wait_pix(b + 4, 20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL grey_timeout got %0d pixels want 4", wq.size() - b); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pix_at(b + i) !== exp[i]) $display("FAIL grey_pix%0d got %h want %h", i, pix_at(b + i), exp[i]); else passed++;
        end
        checks++; if (ok && (wc[b + 3] - wc[b]) !== 3) $display("FAIL grey_consecutive got span %0d want 3", wc[b + 3] - wc[b]); else passed++;
        repeat (4) @(negedge clk);
        checks++; if (rreq_cnt - r0 !== 1) $display("FAIL grey_pops got %0d want 1", rreq_cnt - r0); else passed++;
        checks++; if (wq.size() - b !== 4) $display("FAIL grey_count got %0d want 4", wq.size() - b); else passed++;
    endtask

    task automatic test_16bpp();
        logic [23:0] exp [4];
        int b;
        bit ok;
`ifdef VGA_COLPROC_BITFILL_EN
        exp = '{24'hF80000, 24'h00FC00, 24'hFFFFFF, 24'h0000FF};
`else
        exp = '{24'hF80000, 24'h00FC00, 24'hF8FCF8, 24'h0000F8};
`endif
        bus.ColorDepth = 2'b01;
        b = wq.size();
        push_word(32'hF800_07E0);
        push_word(32'hFFFF_001F);
        wait_pix(b + 4, 20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL rgb565_timeout got %0d pixels want 4", wq.size() - b); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pix_at(b + i) !== exp[i]) $display("FAIL rgb565_pix%0d got %h want %h", i, pix_at(b + i), exp[i]); else passed++;
        end
    endtask

    task automatic test_24bpp();
        logic [23:0] exp [4];
        int b, r0;
        bit ok;
        exp = '{24'h112233, 24'hAABBCC, 24'h445566, 24'h778899};
        bus.ColorDepth = 2'b10;
        b = wq.size(); r0 = rreq_cnt;
        push_word(32'h112233AA);
        push_word(32'hBBCC4455);
        push_word(32'h66778899);
        wait_pix(b + 4, 20, ok);
        checks++; if (ok !== 1'b1) $display("FAIL rgb24_timeout got %0d pixels want 4", wq.size() - b); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pix_at(b + i) !== exp[i]) $display("FAIL rgb24_pix%0d got %h want %h", i, pix_at(b + i), exp[i]); else passed++;
        end
        checks++; if (ok && (wc[b + 3] - wc[b]) !== 3) $display("FAIL rgb24_consecutive got span %0d want 3", wc[b + 3] - wc[b]); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (rreq_cnt - r0 !== 3) $display("FAIL rgb24_pops got %0d want 3", rreq_cnt - r0); else passed++;
    endtask

    task automatic test_stall();
        logic [23:0] exp [8];
        int b, r0, n0, p0;
        bit ok;
        exp = '{24'hA1A1A1, 24'hA2A2A2, 24'hA3A3A3, 24'hA4A4A4,
                24'hB1B1B1, 24'hB2B2B2, 24'hB3B3B3, 24'hB4B4B4};
        bus.ColorDepth = 2'b00; bus.PseudoColor = 1'b0;
        b = wq.size(); r0 = rreq_cnt;
        push_word(32'hA1A2A3A4);
        push_word(32'hB1B2B3B4);
        wait_pix(b + 2, 20, ok);
        bus.RGB_fifo_full = 1'b1;
        n0 = wq.size(); p0 = rreq_cnt;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (wq.size() - b !== 2) $display("FAIL stall_no_wreq got %0d pixels want 2", wq.size() - b); else passed++;
        checks++; if (rreq_cnt !== p0) $display("FAIL stall_no_pop got %0d pops want %0d", rreq_cnt, p0); else passed++;
        bus.RGB_fifo_full = 1'b0;
        wait_pix(b + 8, 30, ok);
        checks++; if (ok !== 1'b1) $display("FAIL stall_timeout got %0d pixels want 8", wq.size() - b); else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++; if (pix_at(b + i) !== exp[i]) $display("FAIL stall_pix%0d got %h want %h", i, pix_at(b + i), exp[i]); else passed++;
        end
        repeat (3) @(negedge clk);
        checks++; if (rreq_cnt - r0 !== 2) $display("FAIL stall_pops got %0d want 2", rreq_cnt - r0); else passed++;
        checks++; if (bus.pixel_buffer_rreq !== 1'b0) $display("FAIL empty_rreq got %b want 0", bus.pixel_buffer_rreq); else passed++;
        checks++; if (bad_pop !== 0) $display("FAIL pop_while_empty got %0d want 0", bad_pop); else passed++;
        checks++; if (n0 - b !== 2) $display("FAIL stall_point got %0d want 2", n0 - b); else passed++;
    endtask

    task automatic test_clut_and_disable();
        int b, r0;
        bit seen;
        bus.ColorDepth = 2'b00; bus.PseudoColor = 1'b1; bus.RGB_fifo_full = 1'b0;
        b = wq.size(); r0 = rreq_cnt;
        push_word(32'h05000000);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.clut_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) $display("FAIL clut_req_timeout got %b want 1", seen); else passed++;
        checks++; if (bus.clut_offs !== 8'h05) $display("FAIL clut_offs got %h want 05", bus.clut_offs); else passed++;
        repeat (2) @(negedge clk);
        checks++; if (bus.clut_req !== 1'b1) $display("FAIL clut_req_held got %b want 1", bus.clut_req); else passed++;
        checks++; if (wq.size() !== b) $display("FAIL clut_early_wreq got %0d pixels want 0", wq.size() - b); else passed++;
        bus.clut_ack = 1'b1;
        bus.wb_di = 32'h00A1B2C3;
        @(negedge clk);
        bus.clut_ack = 1'b0;
        checks++; if (bus.RGB_fifo_wreq !== 1'b1) $display("FAIL clut_wreq got %b want 1", bus.RGB_fifo_wreq); else passed++;
        checks++; if ({bus.R, bus.G, bus.B} !== 24'hA1B2C3) $display("FAIL clut_rgb got %h want a1b2c3", {bus.R, bus.G, bus.B}); else passed++;
        checks++; if (bus.clut_req !== 1'b0) $display("FAIL clut_req_drop got %b want 0", bus.clut_req); else passed++;
        @(negedge clk);
        checks++; if (bus.clut_req !== 1'b1) $display("FAIL clut_req_next got %b want 1", bus.clut_req); else passed++;
        checks++; if (bus.clut_offs !== 8'h00) $display("FAIL clut_offs_next got %h want 00", bus.clut_offs); else passed++;
        checks++; if (bus.RGB_fifo_wreq !== 1'b0) $display("FAIL clut_single_wreq got %b want 0", bus.RGB_fifo_wreq); else passed++;
        bus.ctrl_ven = 1'b0;
        @(negedge clk);
        checks++; if (bus.clut_req !== 1'b0) $display("FAIL ven_clut_req got %b want 0", bus.clut_req); else passed++;
        checks++; if (bus.RGB_fifo_wreq !== 1'b0) $display("FAIL ven_wreq got %b want 0", bus.RGB_fifo_wreq); else passed++;
        checks++; if ({bus.R, bus.G, bus.B} !== 24'h0) $display("FAIL ven_rgb got %h want 000000", {bus.R, bus.G, bus.B}); else passed++;
        bus.ctrl_ven = 1'b1;
        bus.PseudoColor = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rreq_cnt - r0 !== 1) $display("FAIL clut_pops got %0d want 1", rreq_cnt - r0); else passed++;
        checks++; if (wq.size() - b !== 1) $display("FAIL clut_count got %0d want 1", wq.size() - b); else passed++;
    endtask

    task automatic test_phase_restart();
        logic [23:0] exp [4];
        int b;
        bit ok;
        exp = '{24'hC1C2C3, 24'hD1D2D3, 24'hE1E2E3, 24'hF1F2F3};
        bus.ColorDepth = 2'b10; bus.PseudoColor = 1'b0;
        b = wq.size();
        push_word(32'h112233AA);
        wait_pix(b + 1, 20, ok);
        checks++; if (pix_at(b) !== 24'h112233) $display("FAIL phase_first got %h want 112233", pix_at(b)); else passed++;
        repeat (2) @(negedge clk);
        bus.ctrl_ven = 1'b0;
        @(negedge clk);
        bus.ctrl_ven = 1'b1;
        push_word(32'hC1C2C3D1);
        push_word(32'hD2D3E1E2);
        push_word(32'hE3F1F2F3);
        wait_pix(b + 5, 30, ok);
        checks++; if (ok !== 1'b1) $display("FAIL phase_timeout got %0d pixels want 5", wq.size() - b); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (pix_at(b + 1 + i) !== exp[i]) $display("FAIL phase_pix%0d got %h want %h", i, pix_at(b + 1 + i), exp[i]); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ctrl_ven = 1'b1;
        bus.ColorDepth = 2'b00;
        bus.PseudoColor = 1'b0;
        bus.wb_di = 32'h0;
        bus.clut_ack = 1'b0;
        bus.RGB_fifo_full = 1'b0;
        test_reset();
        test_8bpp_grey();
        test_16bpp();
        test_24bpp();
        test_stall();
        test_clut_and_disable();
        test_phase_restart();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
